mant_addsub_pipe: RTL and testbench

Parametrised, pipelined mantissa adder/subtractor for the floating-point ALU datapath. It takes two unsigned WIDTH-bit mantissas and an add/sub select, and returns a sign-magnitude result with carry, a zero flag and a leading-zero count for the normaliser. Valid/ready handshakes on both sides allow backpressure from the normalise/round stage. An opaque tag passes through so the exponent/sign path stays aligned.

---
 rtl/fp_alu_pkg.sv | 8 +
 rtl/mant_lzc.sv | 14 +
 rtl/mant_addsub_pipe.sv | 74 +++++++
 tb/tb_mant_addsub_pipe.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fp_alu_pkg.sv
// fp_alu_pkg: shared opcodes and width helpers for the floating-point ALU datapath
package fp_alu_pkg;
   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;
   function automatic int lzc_w(input int width);
      return $clog2(width + 2);
   endfunction
endpackage

// File: rtl/mant_lzc.sv
// mant_lzc: leading-zero count over a WIDTH+1 bit magnitude; returns WIDTH+1 when all bits are zero
module mant_lzc import fp_alu_pkg::*; #(
   parameter int WIDTH = 24
) (
   input  logic [WIDTH:0]              val_i,
   output logic [lzc_w(WIDTH)-1:0]     cnt_o
);
   // scanning upward lets the highest set bit win the priority
   always_comb begin
      cnt_o = lzc_w(WIDTH)'(WIDTH + 1);
      for (int i = 0; i <= WIDTH; i++)
         if (val_i[i]) cnt_o = lzc_w(WIDTH)'(WIDTH - i);
   end
endmodule

// File: rtl/mant_addsub_pipe.sv
// mant_addsub_pipe: pipelined sign-magnitude mantissa add/sub with global-stall handshake,
// pass-through tag, and zero/leading-zero flags derived from the last stage
module mant_addsub_pipe import fp_alu_pkg::*; #(
   parameter int WIDTH  = 24,
   parameter int STAGES = 2,
   parameter int TAG_W  = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [WIDTH-1:0]        op1,
   input  logic [WIDTH-1:0]        op2,
   input  logic                    operator,
   input  logic [TAG_W-1:0]        in_tag,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH:0]          mag,
   output logic                    sign,
   output logic                    zero,
   output logic [lzc_w(WIDTH)-1:0] lzc,
   output logic [TAG_W-1:0]        out_tag
);
   logic [WIDTH:0]          a, b, mag_d;
   logic                    sign_d, advance;
   logic [lzc_w(WIDTH)-1:0] cnt;

   always_comb begin
      a       = {1'b0, op1};
      b       = {1'b0, op2};
      sign_d  = operator == OP_SUB && op1 < op2;
      mag_d   = operator == OP_ADD ? a + b : sign_d ? b - a : a - b;
      advance = !g_stage[STAGES-1].vld_q || out_ready;
      in_ready = advance;
   end

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      logic [WIDTH:0]     mag_q, mag_in;
      logic               sign_q, sign_in, vld_q, vld_in;
      logic [TAG_W-1:0]   tag_q, tag_in;
      if (s == 0) begin : g_head
         assign {vld_in, sign_in, mag_in, tag_in} = {in_valid, sign_d, mag_d, in_tag};
      end else begin : g_body
         assign {vld_in, sign_in, mag_in, tag_in} =
            {g_stage[s-1].vld_q, g_stage[s-1].sign_q, g_stage[s-1].mag_q, g_stage[s-1].tag_q};
      end
      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n) begin
            vld_q  <= 1'b0;
            sign_q <= 1'b0;
            mag_q  <= '0;
            tag_q  <= '0;
         end else if (advance) begin
            vld_q <= vld_in;
            if (vld_in) begin
               sign_q <= sign_in;
               mag_q  <= mag_in;
               tag_q  <= tag_in;
            end
         end
   end

   mant_lzc #(.WIDTH(WIDTH)) u_lzc (.val_i(g_stage[STAGES-1].mag_q), .cnt_o(cnt));

   // empty slots may hold stale data, so every result field is masked by valid
   always_comb begin
      out_valid = g_stage[STAGES-1].vld_q;
      mag       = out_valid ? g_stage[STAGES-1].mag_q : '0;
      sign      = out_valid && g_stage[STAGES-1].sign_q;
      zero      = out_valid && g_stage[STAGES-1].mag_q == '0;
      lzc       = out_valid ? cnt : '0;
      out_tag   = out_valid ? g_stage[STAGES-1].tag_q : '0;
   end
endmodule

// File: tb/tb_mant_addsub_pipe.sv
// tb_mant_addsub_pipe: directed checks of the mantissa add/sub pipe at STAGES=2, STAGES=1 and WIDTH=11/STAGES=4
module tb_mant_addsub_pipe;
   logic        clk = 0, rst_n = 0, in_valid = 0, op = 0, out_ready = 1;
   logic [23:0] op1 = 0, op2 = 0;
   logic [7:0]  in_tag = 0;
   logic        in_ready, out_valid, sign, zero, in_ready1, out_valid1, sign1, zero1;
   logic [24:0] mag, mag1;
   logic [4:0]  lzc, lzc1;
   logic [7:0]  out_tag, out_tag1;
   logic        v4 = 0, o4 = 0, in_ready4, out_valid4, sign4, zero4;
   logic [10:0] a4 = 0, b4 = 0;
   logic [7:0]  t4 = 0, out_tag4;
   logic [11:0] mag4;
   logic [3:0]  lzc4;
   int n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   mant_addsub_pipe #(.WIDTH(24), .STAGES(2), .TAG_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op1(op1), .op2(op2),
      .operator(op), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .mag(mag),
      .sign(sign), .zero(zero), .lzc(lzc), .out_tag(out_tag));
   mant_addsub_pipe #(.WIDTH(24), .STAGES(1), .TAG_W(8)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .op1(op1), .op2(op2),
      .operator(op), .in_tag(in_tag), .out_valid(out_valid1), .out_ready(out_ready), .mag(mag1),
      .sign(sign1), .zero(zero1), .lzc(lzc1), .out_tag(out_tag1));
   mant_addsub_pipe #(.WIDTH(11), .STAGES(4), .TAG_W(8)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(in_ready4), .op1(a4), .op2(b4),
      .operator(o4), .in_tag(t4), .out_valid(out_valid4), .out_ready(out_ready), .mag(mag4),
      .sign(sign4), .zero(zero4), .lzc(lzc4), .out_tag(out_tag4));

   task automatic chk(input string t, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", t, obs, exp);
      end
   endtask

   function automatic logic [25:0] ref_res(input logic [23:0] a, input logic [23:0] b, input logic o);
      if (!o) return {1'b0, {1'b0, a} + {1'b0, b}};
      if (a < b) return {1'b1, {1'b0, b} - {1'b0, a}};
      return {1'b0, {1'b0, a} - {1'b0, b}};
   endfunction

   function automatic logic [4:0] ref_lzc(input logic [24:0] m);
      for (int i = 24; i >= 0; i--) if (m[i]) return 5'(24 - i);
      return 5'd25;
   endfunction

   // one op through the STAGES=2 and STAGES=1 instances together
   task automatic op_check(input string t, input logic [23:0] a, input logic [23:0] b, input logic o,
                           input logic [7:0] tg, input logic [24:0] em, input logic es, input logic [4:0] el);
      @(negedge clk); op1 = a; op2 = b; op = o; in_tag = tg; in_valid = 1;
      @(negedge clk); in_valid = 0;
      chk({t, " s1 valid"}, out_valid1, 1);
      chk({t, " s1 mag"}, mag1, em);
      chk({t, " s1 sign"}, sign1, es);
      chk({t, " s1 lzc"}, lzc1, el);
      chk({t, " s1 zero"}, zero1, em == 0);
      chk({t, " s2 early"}, out_valid, 0);
      @(negedge clk);
      chk({t, " s2 valid"}, out_valid, 1);
      chk({t, " s2 mag"}, mag, em);
      chk({t, " s2 sign"}, sign, es);
      chk({t, " s2 zero"}, zero, em == 0);
      chk({t, " s2 lzc"}, lzc, el);
      chk({t, " s2 tag"}, out_tag, tg);
      chk({t, " s1 drained"}, out_valid1, 0);
   endtask

   task automatic op4_check(input string t, input logic [10:0] a, input logic [10:0] b, input logic o,
                            input logic [11:0] em, input logic es, input logic [3:0] el);
      @(negedge clk); a4 = a; b4 = b; o4 = o; t4 = 8'h4C; v4 = 1;
      @(negedge clk); v4 = 0;
      repeat (2) @(negedge clk);
      chk({t, " w11 early"}, out_valid4, 0);
      @(negedge clk);
      chk({t, " w11 valid"}, out_valid4, 1);
      chk({t, " w11 mag"}, mag4, em);
      chk({t, " w11 sign"}, sign4, es);
      chk({t, " w11 zero"}, zero4, em == 0);
      chk({t, " w11 lzc"}, lzc4, el);
      chk({t, " w11 tag"}, out_tag4, 8'h4C);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [25:0] exp_q[$];
      logic [7:0]  tag_q[$];
      logic [25:0] e;
      int first, got;
      #12;
      chk("rst out_valid", out_valid, 0);
      chk("rst mag", mag, 0);
      chk("rst lzc", lzc, 0);
      chk("rst in_ready", in_ready, 1);
      @(negedge clk); rst_n = 1;

      op_check("add carry", 24'hFFFFFF, 24'h000001, 0, 8'hA5, 25'h1000000, 0, 0);
      op_check("sub neg", 24'h000005, 24'h000009, 1, 8'h11, 25'h0000004, 1, 22);
      op_check("sub pos", 24'h800000, 24'h000001, 1, 8'h22, 25'h07FFFFF, 0, 2);
      op_check("sub eq", 24'h123456, 24'h123456, 1, 8'h33, 25'h0, 0, 25);
      op_check("add half", 24'h400000, 24'h400000, 0, 8'h44, 25'h0800000, 0, 1);

      // back-to-back random stream with tags 0..9
      first = -1; got = 0;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         if (out_valid) begin
            if (first < 0) first = c;
            e = exp_q.pop_front();
            chk("rnd mag", mag, e[24:0]);
            chk("rnd sign", sign, e[25]);
            chk("rnd lzc", lzc, ref_lzc(e[24:0]));
            chk("rnd tag", out_tag, tag_q.pop_front());
            got++;
         end
         if (c < 10) begin
            op1 = 24'($urandom); op2 = 24'($urandom); op = 1'($urandom); in_tag = 8'(c); in_valid = 1;
            exp_q.push_back(ref_res(op1, op2, op)); tag_q.push_back(8'(c));
         end else in_valid = 0;
      end
      chk("rnd first cycle", first, 2);
      chk("rnd count", got, 10);

      // stall: three ops, out_ready low for five cycles
      out_ready = 0;
      @(negedge clk); op1 = 24'h10; op2 = 24'h20; op = 0; in_tag = 8'hB0; in_valid = 1;
      @(negedge clk); op1 = 24'h30; op2 = 24'h08; op = 1; in_tag = 8'hB1;
      @(negedge clk); op1 = 24'h05; op2 = 24'h50; op = 1; in_tag = 8'hB2;
      for (int c = 0; c < 5; c++) begin
         chk("stall in_ready", in_ready, 0);
         chk("stall valid", out_valid, 1);
         chk("stall mag", mag, 25'h30);
         chk("stall tag", out_tag, 8'hB0);
         @(negedge clk);
      end
      out_ready = 1;
      @(negedge clk); in_valid = 0;
      chk("drain B mag", mag, 25'h28);
      chk("drain B tag", out_tag, 8'hB1);
      @(negedge clk);
      chk("drain C mag", mag, 25'h4B);
      chk("drain C sign", sign, 1);
      chk("drain C tag", out_tag, 8'hB2);
      @(negedge clk);
      chk("drain empty", out_valid, 0);

      // asynchronous reset with two ops in flight
      @(negedge clk); op1 = 24'h1; op2 = 24'h2; op = 0; in_tag = 8'hC0; in_valid = 1;
      @(negedge clk); in_tag = 8'hC1;
      @(negedge clk); in_valid = 0;
      #2 rst_n = 0;
      #1;
      chk("arst valid", out_valid, 0);
      chk("arst mag", mag, 0);
      chk("arst sign", sign, 0);
      chk("arst zero", zero, 0);
      chk("arst lzc", lzc, 0);
      chk("arst tag", out_tag, 0);
      @(negedge clk); rst_n = 1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("post rst quiet", out_valid, 0);
      end
      op_check("post rst", 24'h000100, 24'h000001, 0, 8'h5A, 25'h0000101, 0, 16);

      op4_check("add max", 11'h7FF, 11'h7FF, 0, 12'hFFE, 0, 0);
      op4_check("sub neg", 11'h005, 11'h009, 1, 12'h004, 1, 9);
      op4_check("sub pos", 11'h400, 11'h001, 1, 12'h3FF, 0, 2);
      op4_check("sub eq", 11'h2AB, 11'h2AB, 1, 12'h000, 0, 12);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
